// File: rtl/id_ex_hazard_reg_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_reg_pkg
//   Shared definitions for the ID/EX pipeline register and its hazard logic:
//   - stall_state_e : stall FSM state encoding (RUN=0, BR_WAIT=1)
//   - id_ex_ctrl_t  : the control bundle carried from ID into EX
//   - CTRL_BUBBLE   : control bundle of an inserted bubble (all zero)
//   - reg_match()   : operand dependency test against a destination register
// ---------------------------------------------------------------------------
package id_ex_hazard_reg_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } stall_state_e;

    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       uses_rt;
        logic       branch;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

    // $0 is hard-wired to zero, so a write to it can never be a dependency.
    function automatic logic reg_match(input logic [4:0] r,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       uses_rt);
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

endpackage

// File: rtl/id_ex_hazard_reg_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
//   Purely combinational hazard classification for the instruction in ID.
//   Ports:
//     id_branch_i, id_uses_rt_i, id_rs_i, id_rt_i : instruction in ID
//     ex_mem_read_i, ex_reg_write_i, ex_write_reg_i : instruction in EX
//     mem_mem_read_i, mem_write_reg_i              : instruction in MEM
//     lu_o  : load in EX feeds an operand in ID
//     ba_o  : branch needs an ALU result still in EX
//     blm_o : branch needs a load result still in MEM
//     ble_o : branch needs a load result still in EX (two-cycle wait)
// ---------------------------------------------------------------------------
module hazard_detect
    import id_ex_hazard_reg_pkg::*;
(
    input  logic       id_branch_i,
    input  logic       id_uses_rt_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_reg_write_i,
    input  logic [4:0] ex_write_reg_i,
    input  logic       mem_mem_read_i,
    input  logic [4:0] mem_write_reg_i,
    output logic       lu_o,
    output logic       ba_o,
    output logic       blm_o,
    output logic       ble_o
);

    logic ex_match;
    logic mem_match;

    always_comb begin
        ex_match  = reg_match(ex_write_reg_i, id_rs_i, id_rt_i, id_uses_rt_i);
        mem_match = reg_match(mem_write_reg_i, id_rs_i, id_rt_i, id_uses_rt_i);

        lu_o  = ex_mem_read_i && ex_match;
        ba_o  = id_branch_i && ex_reg_write_i && !ex_mem_read_i && ex_match;
        blm_o = id_branch_i && mem_mem_read_i && mem_match;
        ble_o = id_branch_i && ex_mem_read_i && ex_match;
    end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_reg
//   ID/EX pipeline register of a 5-stage MIPS pipe with load-use and
//   branch-compare hazard detection and a saturating stall-cycle counter.
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     Hold            : global freeze, no state changes
//     Flush           : kill the instruction in ID (load a bubble)
//     IF_ID_Rs/Rt/Rd  : register fields of the instruction in ID
//     ID_*            : decoded controls, operands and immediate from ID
//     EX_MemMemRead,
//     EX_MemWriteReg  : load flag / destination of the instruction in MEM
//     ID_Ex_*         : registered copies of the ID fields, plus WriteReg
//     PCWrite         : 0 holds the PC
//     IF_IDWrite      : 0 holds the IF/ID register
//     StallCnt        : total stall cycles, saturating at all-ones
// ---------------------------------------------------------------------------
module id_ex_hazard_reg
    import id_ex_hazard_reg_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Hold,
    input  logic              Flush,
    input  logic [4:0]        IF_ID_Rs,
    input  logic [4:0]        IF_ID_Rt,
    input  logic [4:0]        IF_ID_Rd,
    input  logic              ID_UsesRt,
    input  logic              ID_Branch,
    input  logic              ID_RegDst,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_MemtoReg,
    input  logic              ID_ALUSrc,
    input  logic [3:0]        ID_ALUOp,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_SignExt,
    input  logic              EX_MemMemRead,
    input  logic [4:0]        EX_MemWriteReg,
    output logic              ID_Ex_UsesRt,
    output logic              ID_Ex_Branch,
    output logic              ID_Ex_RegDst,
    output logic              ID_Ex_RegWrite,
    output logic              ID_Ex_MemRead,
    output logic              ID_Ex_MemWrite,
    output logic              ID_Ex_MemtoReg,
    output logic              ID_Ex_ALUSrc,
    output logic [3:0]        ID_Ex_ALUOp,
    output logic [DATA_W-1:0] ID_Ex_ReadData1,
    output logic [DATA_W-1:0] ID_Ex_ReadData2,
    output logic [DATA_W-1:0] ID_Ex_SignExt,
    output logic [4:0]        ID_Ex_Rs,
    output logic [4:0]        ID_Ex_Rt,
    output logic [4:0]        ID_Ex_Rd,
    output logic [4:0]        ID_Ex_WriteReg,
    output logic              PCWrite,
    output logic              IF_IDWrite,
    output logic [CNT_W-1:0]  StallCnt
);

    stall_state_e      state_q, state_d;
    id_ex_ctrl_t       ctrl_q,  ctrl_d, ctrl_in;
    logic [DATA_W-1:0] rd1_q,   rd1_d;
    logic [DATA_W-1:0] rd2_q,   rd2_d;
    logic [DATA_W-1:0] sext_q,  sext_d;
    logic [4:0]        rs_q,    rs_d;
    logic [4:0]        rt_q,    rt_d;
    logic [4:0]        rd_q,    rd_d;
    logic [4:0]        wreg_q,  wreg_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic hz_lu, hz_ba, hz_blm, hz_ble;
    logic stall;

    hazard_detect u_hazard_detect (
        .id_branch_i     (ID_Branch),
        .id_uses_rt_i    (ID_UsesRt),
        .id_rs_i         (IF_ID_Rs),
        .id_rt_i         (IF_ID_Rt),
        .ex_mem_read_i   (ctrl_q.mem_read),
        .ex_reg_write_i  (ctrl_q.reg_write),
        .ex_write_reg_i  (wreg_q),
        .mem_mem_read_i  (EX_MemMemRead),
        .mem_write_reg_i (EX_MemWriteReg),
        .lu_o            (hz_lu),
        .ba_o            (hz_ba),
        .blm_o           (hz_blm),
        .ble_o           (hz_ble)
    );

    always_comb begin
        ctrl_in = '{
            reg_dst:    ID_RegDst,
            reg_write:  ID_RegWrite,
            mem_read:   ID_MemRead,
            mem_write:  ID_MemWrite,
            mem_to_reg: ID_MemtoReg,
            alu_src:    ID_ALUSrc,
            alu_op:     ID_ALUOp,
            uses_rt:    ID_UsesRt,
            branch:     ID_Branch
        };
    end

    // Hazards are only looked at in RUN; BR_WAIT stalls unconditionally.
    always_comb begin
        stall = (state_q == BR_WAIT) ||
                ((state_q == RUN) && (hz_lu || hz_ba || hz_blm || hz_ble));
    end

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        sext_d  = sext_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        wreg_d  = wreg_q;
        cnt_d   = cnt_q;

        if (!Hold) begin
            // Data fields always advance; only the controls are bubbled.
            rd1_d  = ID_ReadData1;
            rd2_d  = ID_ReadData2;
            sext_d = ID_SignExt;
            rs_d   = IF_ID_Rs;
            rt_d   = IF_ID_Rt;
            rd_d   = IF_ID_Rd;
            wreg_d = ID_RegDst ? IF_ID_Rd : IF_ID_Rt;

            if (Flush) begin
                ctrl_d  = CTRL_BUBBLE;
                state_d = RUN;
            end else if (stall) begin
                ctrl_d  = CTRL_BUBBLE;
                state_d = ((state_q == RUN) && hz_ble) ? BR_WAIT : RUN;
            end else begin
                ctrl_d  = ctrl_in;
                state_d = RUN;
            end

            // Counted even when Flush coincides; Flush alone never counts.
            if (stall && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            ctrl_q  <= CTRL_BUBBLE;
            rd1_q   <= '0;
            rd2_q   <= '0;
            sext_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            wreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            sext_q  <= sext_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            wreg_q  <= wreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // PC and IF/ID keep running while reset is asserted.
    always_comb begin
        PCWrite    = rst || (!Hold && !stall);
        IF_IDWrite = rst || (!Hold && !stall);
    end

    assign ID_Ex_UsesRt    = ctrl_q.uses_rt;
    assign ID_Ex_Branch    = ctrl_q.branch;
    assign ID_Ex_RegDst    = ctrl_q.reg_dst;
    assign ID_Ex_RegWrite  = ctrl_q.reg_write;
    assign ID_Ex_MemRead   = ctrl_q.mem_read;
    assign ID_Ex_MemWrite  = ctrl_q.mem_write;
    assign ID_Ex_MemtoReg  = ctrl_q.mem_to_reg;
    assign ID_Ex_ALUSrc    = ctrl_q.alu_src;
    assign ID_Ex_ALUOp     = ctrl_q.alu_op;
    assign ID_Ex_ReadData1 = rd1_q;
    assign ID_Ex_ReadData2 = rd2_q;
    assign ID_Ex_SignExt   = sext_q;
    assign ID_Ex_Rs        = rs_q;
    assign ID_Ex_Rt        = rt_q;
    assign ID_Ex_Rd        = rd_q;
    assign ID_Ex_WriteReg  = wreg_q;
    assign StallCnt        = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
module tb_id_ex_hazard_reg;

    localparam int DW      = 32;
    localparam int CW      = 3;
    localparam int CNT_MAX = 7;

    logic          clk = 1'b0;
    logic          rst, Hold, Flush;
    logic [4:0]    IF_ID_Rs, IF_ID_Rt, IF_ID_Rd;
    logic          ID_UsesRt, ID_Branch, ID_RegDst, ID_RegWrite, ID_MemRead;
    logic          ID_MemWrite, ID_MemtoReg, ID_ALUSrc;
    logic [3:0]    ID_ALUOp;
    logic [DW-1:0] ID_ReadData1, ID_ReadData2, ID_SignExt;
    logic          EX_MemMemRead;
    logic [4:0]    EX_MemWriteReg;
    logic          ID_Ex_UsesRt, ID_Ex_Branch, ID_Ex_RegDst, ID_Ex_RegWrite, ID_Ex_MemRead;
    logic          ID_Ex_MemWrite, ID_Ex_MemtoReg, ID_Ex_ALUSrc;
    logic [3:0]    ID_Ex_ALUOp;
    logic [DW-1:0] ID_Ex_ReadData1, ID_Ex_ReadData2, ID_Ex_SignExt;
    logic [4:0]    ID_Ex_Rs, ID_Ex_Rt, ID_Ex_Rd, ID_Ex_WriteReg;
    logic          PCWrite, IF_IDWrite;
    logic [CW-1:0] StallCnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_hazard_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .Hold(Hold), .Flush(Flush),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_Rd(IF_ID_Rd),
        .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch), .ID_RegDst(ID_RegDst),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_ALUOp(ID_ALUOp),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_SignExt(ID_SignExt),
        .EX_MemMemRead(EX_MemMemRead), .EX_MemWriteReg(EX_MemWriteReg),
        .ID_Ex_UsesRt(ID_Ex_UsesRt), .ID_Ex_Branch(ID_Ex_Branch), .ID_Ex_RegDst(ID_Ex_RegDst),
        .ID_Ex_RegWrite(ID_Ex_RegWrite), .ID_Ex_MemRead(ID_Ex_MemRead),
        .ID_Ex_MemWrite(ID_Ex_MemWrite), .ID_Ex_MemtoReg(ID_Ex_MemtoReg),
        .ID_Ex_ALUSrc(ID_Ex_ALUSrc), .ID_Ex_ALUOp(ID_Ex_ALUOp),
        .ID_Ex_ReadData1(ID_Ex_ReadData1), .ID_Ex_ReadData2(ID_Ex_ReadData2),
        .ID_Ex_SignExt(ID_Ex_SignExt), .ID_Ex_Rs(ID_Ex_Rs), .ID_Ex_Rt(ID_Ex_Rt),
        .ID_Ex_Rd(ID_Ex_Rd), .ID_Ex_WriteReg(ID_Ex_WriteReg),
        .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite), .StallCnt(StallCnt)
    );

    // Reference model: the instruction sitting in EX, a "branch still waiting
    // on a load" flag, and the stall total.
    typedef struct packed {
        logic       regdst, regwrite, memread, memwrite, memtoreg, alusrc;
        logic [3:0] aluop;
        logic       usesrt, branch;
        logic [4:0] rs, rt, rd, wreg;
        logic [DW-1:0] rd1, rd2, sx;
    } ex_t;

    ex_t m_ex;
    bit  m_wait;
    int  m_cnt;

    function automatic bit mmatch(input logic [4:0] r);
        return (r != 0) && ((r == IF_ID_Rs) || (ID_UsesRt && (r == IF_ID_Rt)));
    endfunction

    // Branch-on-load-in-EX is a special case of the load-use test.
    function automatic bit model_stall();
        bit lu, ba, blm;
        if (m_wait) return 1'b1;
        lu  = m_ex.memread && mmatch(m_ex.wreg);
        ba  = ID_Branch && m_ex.regwrite && !m_ex.memread && mmatch(m_ex.wreg);
        blm = ID_Branch && EX_MemMemRead && mmatch(EX_MemWriteReg);
        return lu || ba || blm;
    endfunction

    function automatic bit model_pcw();
        return rst || (!Hold && !model_stall());
    endfunction

    function automatic logic [130:0] model_vec();
        return {m_ex, 3'(m_cnt)};
    endfunction

    function automatic logic [130:0] dut_vec();
        return {ID_Ex_RegDst, ID_Ex_RegWrite, ID_Ex_MemRead, ID_Ex_MemWrite, ID_Ex_MemtoReg,
                ID_Ex_ALUSrc, ID_Ex_ALUOp, ID_Ex_UsesRt, ID_Ex_Branch,
                ID_Ex_Rs, ID_Ex_Rt, ID_Ex_Rd, ID_Ex_WriteReg,
                ID_Ex_ReadData1, ID_Ex_ReadData2, ID_Ex_SignExt, StallCnt};
    endfunction

    task automatic model_reset();
        m_ex   = '0;
        m_wait = 1'b0;
        m_cnt  = 0;
    endtask

    // Advance one clock edge, updating the model from the inputs in force.
    task automatic tick();
        bit st, nw, kill;
        st   = model_stall();
        nw   = !Flush && !m_wait && st && ID_Branch && m_ex.memread && mmatch(m_ex.wreg);
        kill = st || Flush;
        @(posedge clk);
        if (!rst && !Hold) begin
            if (st && m_cnt < CNT_MAX) m_cnt++;
            m_ex.rs   = IF_ID_Rs;
            m_ex.rt   = IF_ID_Rt;
            m_ex.rd   = IF_ID_Rd;
            m_ex.wreg = ID_RegDst ? IF_ID_Rd : IF_ID_Rt;
            m_ex.rd1  = ID_ReadData1;
            m_ex.rd2  = ID_ReadData2;
            m_ex.sx   = ID_SignExt;
            m_ex.regdst   = kill ? 1'b0 : ID_RegDst;
            m_ex.regwrite = kill ? 1'b0 : ID_RegWrite;
            m_ex.memread  = kill ? 1'b0 : ID_MemRead;
            m_ex.memwrite = kill ? 1'b0 : ID_MemWrite;
            m_ex.memtoreg = kill ? 1'b0 : ID_MemtoReg;
            m_ex.alusrc   = kill ? 1'b0 : ID_ALUSrc;
            m_ex.aluop    = kill ? 4'd0 : ID_ALUOp;
            m_ex.usesrt   = kill ? 1'b0 : ID_UsesRt;
            m_ex.branch   = kill ? 1'b0 : ID_Branch;
            m_wait = nw;
        end
        #1;
    endtask

    task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input bit usesrt, input bit br, input bit regdst,
                             input bit regwrite, input bit memread, input bit memwrite);
        IF_ID_Rs     = rs;
        IF_ID_Rt     = rt;
        IF_ID_Rd     = rd;
        ID_UsesRt    = usesrt;
        ID_Branch    = br;
        ID_RegDst    = regdst;
        ID_RegWrite  = regwrite;
        ID_MemRead   = memread;
        ID_MemWrite  = memwrite;
        ID_MemtoReg  = memread;
        ID_ALUSrc    = !regdst;
        ID_ALUOp     = 4'($urandom_range(1, 15));
        ID_ReadData1 = $urandom;
        ID_ReadData2 = $urandom;
        ID_SignExt   = $urandom;
    endtask

    task automatic do_reset();
        Hold = 0; Flush = 0; EX_MemMemRead = 0; EX_MemWriteReg = 0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        model_reset();
        #7;
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        Hold = 0; Flush = 0;
        set_instr(3, 1, 2, 1, 1, 1, 1, 1, 0);
        EX_MemMemRead = 1; EX_MemWriteReg = 3;   // hazardous inputs while in reset
        rst = 1;
        model_reset();
        #3;
        total++;
        if (dut_vec() !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", dut_vec());
        end
        total++;
        if ({PCWrite, IF_IDWrite} !== 2'b11) begin
            bad++; $display("FAIL reset_pcwrite got=%b exp=11", {PCWrite, IF_IDWrite});
        end
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        set_instr(2, 8, 0, 0, 0, 0, 1, 1, 0);       // lw $8
        tick();
        set_instr(8, 3, 9, 1, 0, 1, 1, 0, 0);       // add $9,$8,$3
        #1;
        total++;
        if ({PCWrite, IF_IDWrite} !== 2'b00) begin
            bad++; $display("FAIL lu_stall got=%b exp=00", {PCWrite, IF_IDWrite});
        end
        tick();
        total++;
        if (ID_Ex_RegWrite !== 1'b0 || StallCnt !== 3'd1) begin
            bad++; $display("FAIL lu_bubble got=%b/%0d exp=0/1", ID_Ex_RegWrite, StallCnt);
        end
        total++;
        if (PCWrite !== 1'b1) begin
            bad++; $display("FAIL lu_one_cycle got=%b exp=1", PCWrite);
        end
        tick();
        total++;
        if (ID_Ex_RegWrite !== 1'b1 || ID_Ex_WriteReg !== 5'd9 || dut_vec() !== model_vec()) begin
            bad++; $display("FAIL lu_release got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_branch_alu();
        do_reset();
        set_instr(1, 2, 5, 1, 0, 1, 1, 0, 0);       // add $5
        tick();
        set_instr(5, 6, 0, 1, 1, 0, 0, 0, 0);       // beq $5,$6
        #1;
        total++;
        if (PCWrite !== 1'b0) begin
            bad++; $display("FAIL ba_stall got=%b exp=0", PCWrite);
        end
        tick();
        total++;
        if (ID_Ex_Branch !== 1'b0 || PCWrite !== 1'b1) begin
            bad++; $display("FAIL ba_bubble got=%b/%b exp=0/1", ID_Ex_Branch, PCWrite);
        end
        tick();
        total++;
        if (ID_Ex_Branch !== 1'b1 || ID_Ex_Rs !== 5'd5 || ID_Ex_Rt !== 5'd6 || StallCnt !== 3'd1) begin
            bad++; $display("FAIL ba_enter got=%b/%0d/%0d/%0d exp=1/5/6/1",
                            ID_Ex_Branch, ID_Ex_Rs, ID_Ex_Rt, StallCnt);
        end
    endtask

    task automatic test_branch_load();
        do_reset();
        set_instr(1, 4, 0, 0, 0, 0, 1, 1, 0);       // lw $4
        tick();
        set_instr(4, 0, 0, 1, 1, 0, 0, 0, 0);       // beq $4,$0
        #1;
        total++;
        if (PCWrite !== 1'b0) begin
            bad++; $display("FAIL ble_stall1 got=%b exp=0", PCWrite);
        end
        tick();
        total++;
        if (PCWrite !== 1'b0 || IF_IDWrite !== 1'b0) begin
            bad++; $display("FAIL ble_stall2 got=%b%b exp=00", PCWrite, IF_IDWrite);
        end
        tick();
        total++;
        if (PCWrite !== 1'b1 || StallCnt !== 3'd2) begin
            bad++; $display("FAIL ble_release got=%b/%0d exp=1/2", PCWrite, StallCnt);
        end
        tick();
        total++;
        if (ID_Ex_Branch !== 1'b1 || dut_vec() !== model_vec()) begin
            bad++; $display("FAIL ble_enter got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_no_stall();
        do_reset();
        set_instr(1, 0, 0, 0, 0, 0, 1, 1, 0);       // lw $0
        tick();
        set_instr(0, 0, 9, 1, 0, 1, 1, 0, 0);       // add $9,$0,$0
        #1;
        total++;
        if (PCWrite !== 1'b1) begin
            bad++; $display("FAIL zero_reg got=%b exp=1", PCWrite);
        end
        set_instr(2, 7, 0, 0, 0, 0, 1, 1, 0);       // lw $7
        tick();
        set_instr(1, 7, 0, 0, 0, 0, 0, 0, 1);       // sw, Rt not read
        #1;
        total++;
        if (PCWrite !== 1'b1) begin
            bad++; $display("FAIL no_usesrt got=%b exp=1", PCWrite);
        end
        ID_UsesRt = 1;
        #1;
        total++;
        if (PCWrite !== 1'b0) begin
            bad++; $display("FAIL usesrt_match got=%b exp=0", PCWrite);
        end
        tick();
    endtask

    task automatic test_hold();
        do_reset();
        set_instr(1, 4, 0, 0, 0, 0, 1, 1, 0);
        tick();
        set_instr(4, 0, 0, 1, 1, 0, 0, 0, 0);
        tick();                                     // now waiting a second cycle
        Hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (PCWrite !== 1'b0) begin
                bad++; $display("FAIL hold_pcw[%0d] got=%b exp=0", i, PCWrite);
            end
            tick();
            total++;
            if (dut_vec() !== model_vec() || StallCnt !== 3'd1) begin
                bad++; $display("FAIL hold_frozen[%0d] got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        Hold = 0;
        #1;
        total++;
        if (PCWrite !== 1'b0) begin
            bad++; $display("FAIL hold_release_stall got=%b exp=0", PCWrite);
        end
        tick();
        total++;
        if (PCWrite !== 1'b1 || StallCnt !== 3'd2) begin
            bad++; $display("FAIL hold_after got=%b/%0d exp=1/2", PCWrite, StallCnt);
        end
    endtask

    task automatic test_async_reset_flush();
        do_reset();
        set_instr(1, 4, 0, 0, 0, 0, 1, 1, 0);
        tick();
        set_instr(4, 0, 0, 1, 1, 0, 0, 0, 0);
        tick();
        #2 rst = 1;
        model_reset();
        #1;
        total++;
        if (dut_vec() !== '0 || PCWrite !== 1'b1) begin
            bad++; $display("FAIL async_rst got=%h/%b exp=0/1", dut_vec(), PCWrite);
        end
        #1 rst = 0;
        #1;
        total++;
        if (PCWrite !== 1'b1) begin
            bad++; $display("FAIL rst_state_run got=%b exp=1", PCWrite);
        end
        // Flush together with a branch-on-load stall: bubble, counted, back to RUN.
        set_instr(1, 4, 0, 0, 0, 0, 1, 1, 0);
        tick();
        set_instr(4, 0, 0, 1, 1, 0, 0, 0, 0);
        Flush = 1;
        #1;
        total++;
        if (PCWrite !== 1'b0) begin
            bad++; $display("FAIL flush_stall_pcw got=%b exp=0", PCWrite);
        end
        tick();
        Flush = 0;
        #1;
        total++;
        if (ID_Ex_Branch !== 1'b0 || StallCnt !== 3'd1 || PCWrite !== 1'b1) begin
            bad++; $display("FAIL flush_stall got=%b/%0d/%b exp=0/1/1", ID_Ex_Branch, StallCnt, PCWrite);
        end
        // Flush alone is not a stall.
        set_instr(1, 2, 3, 1, 0, 1, 1, 0, 0);
        Flush = 1;
        tick();
        Flush = 0;
        total++;
        if (ID_Ex_RegWrite !== 1'b0 || StallCnt !== 3'd1) begin
            bad++; $display("FAIL flush_only got=%b/%0d exp=0/1", ID_Ex_RegWrite, StallCnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom),
                      1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0));
            EX_MemMemRead  = 1'($urandom_range(0, 3) == 0);
            EX_MemWriteReg = 5'($urandom_range(0, 3));
            Hold  = 1'($urandom_range(0, 7) == 0);
            Flush = 1'($urandom_range(0, 9) == 0);
            #1;
            total++;
            if ({PCWrite, IF_IDWrite} !== {2{model_pcw()}}) begin
                bad++; $display("FAIL rnd_pcw[%0d] got=%b exp=%b", i, {PCWrite, IF_IDWrite}, {2{model_pcw()}});
            end
            tick();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL rnd_regs[%0d] got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        Hold = 0; Flush = 0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_alu();
        test_branch_load();
        test_no_stall();
        test_hold();
        test_async_reset_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
